// File: rtl/pulse_meter_pkg.sv
// ============================================================================
// Module   : pulse_meter_pkg
// Brief    : Shared types and default constants for the pulse meter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_meter_pkg;

  // Measurement FSM: IDLE until the first rise, then alternates HIGH/LOW.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int CNT_WIDTH_DEF = 24;
  localparam int TIMEOUT_DEF   = 10_000_000;

endpackage : pulse_meter_pkg

`default_nettype wire

// File: rtl/pulse_meter_sync_edge_detect.sv
// ============================================================================
// Module   : pulse_meter_sync_edge_detect
// Brief    : Multi-flop synchroniser for an asynchronous input followed by a
//            history flop that yields single-cycle rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_meter_sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain, then remember the
  // previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_hist <= w_synced;
    end
  end

  assign o_rise = w_synced & ~r_hist;
  assign o_fall = ~w_synced & r_hist;

endmodule : pulse_meter_sync_edge_detect

`default_nettype wire

// File: rtl/pulse_meter.sv
// ============================================================================
// Module   : pulse_meter
// Brief    : Measures period and high time of an asynchronous pulse train in
//            CLOCK_50MHZ cycles; publishes both with a one-cycle VALID strobe
//            and raises a sticky TIMEOUT for a dead or stuck input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 CLOCK_50MHZ,
  input  logic                 RESET_N,
  input  logic                 PULSE_IN,
  output logic [CNT_WIDTH-1:0] PERIOD,
  output logic [CNT_WIDTH-1:0] HIGH_TIME,
  output logic                 VALID,
  output logic                 TIMEOUT
);

  localparam logic [CNT_WIDTH-1:0] c_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic                 w_rise;
  logic                 w_fall;
  logic                 w_cnt_sat;
  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_capture;
  logic                 w_shadow_ld;
  logic                 w_timeout_set;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_shadow_high;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_high_time;
  logic                 r_valid;
  logic                 r_timeout;
  logic                 r_seen_edge;

  pulse_meter_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk    (CLOCK_50MHZ),
    .rst_n  (RESET_N),
    .i_din  (PULSE_IN),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_cnt_sat = (r_cnt == c_TIMEOUT);

  // Free-running cycle counter: restarts at 1 on every rise, parks at the
  // timeout value so a dead input can never wrap it into a bogus period.
  always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (!w_cnt_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and action decode; a rise always beats a coincident timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_shadow_ld   = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
        end else if (w_cnt_sat && r_seen_edge) begin
          w_timeout_set = 1'b1;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_shadow_ld = 1'b1;
          w_state_nxt = LOW;
        end else if (w_cnt_sat) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = HIGH;
        end else if (w_cnt_sat) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Result registers, strobe and sticky timeout flag.
  always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_shadow_high <= '0;
      r_period      <= '0;
      r_high_time   <= '0;
      r_valid       <= 1'b0;
      r_timeout     <= 1'b0;
      r_seen_edge   <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_rise || w_fall) begin
        r_seen_edge <= 1'b1;
      end
      if (w_shadow_ld) begin
        r_shadow_high <= r_cnt;
      end
      if (w_capture) begin
        r_period    <= r_cnt;
        r_high_time <= r_shadow_high;
        r_timeout   <= 1'b0;
      end else if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign PERIOD    = r_period;
  assign HIGH_TIME = r_high_time;
  assign VALID     = r_valid;
  assign TIMEOUT   = r_timeout;

endmodule : pulse_meter

`default_nettype wire

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
Measures the period and high time of an external pulse train in CLOCK_50MHZ cycles. It is the receive-side counterpart of the clock divider and pulse generation logic: it checks generated waveforms in loopback, for example 500 Hz gives 100000 cycles and 1 MHz gives 50 cycles. PULSE_IN is asynchronous and is synchronised internally. Results publish together with a one-cycle VALID strobe, and a timeout flags a dead or stuck input.

Parameters:
CNT_WIDTH, 24, width of the cycle counter and of the PERIOD/HIGH_TIME outputs
SYNC_STAGES, 2, number of synchroniser flops on PULSE_IN (minimum 2)
TIMEOUT_CYCLES, 10_000_000, cycles without a qualifying edge before TIMEOUT is raised; must be less than 2^CNT_WIDTH

Ports:
CLOCK_50MHZ  input  1  sole clock; all logic is on its rising edge
RESET_N  input  1  asynchronous, active-low reset
PULSE_IN  input  1  asynchronous pulse train to measure
PERIOD  output  CNT_WIDTH  cycles from one detected rising edge to the next
HIGH_TIME  output  CNT_WIDTH  cycles from a detected rising edge to the following detected falling edge
VALID  output  1  one-cycle strobe; PERIOD and HIGH_TIME updated this cycle
TIMEOUT  output  1  sticky flag; no complete period within TIMEOUT_CYCLES

Behaviour:
- Reset (async assert, sync release): PERIOD=0, HIGH_TIME=0, VALID=0, TIMEOUT=0, synchroniser flops=0, edge-history flop=0, counter=0, state=IDLE.
- Synchroniser:
  - PULSE_IN passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Detection lags the PIN transition by SYNC_STAGES to SYNC_STAGES+1 cycles.
- Counter:
  - On each rise the counter loads 1; otherwise it increments by 1 per cycle.
  - The counter saturates at TIMEOUT_CYCLES and never wraps.
  - If two rises are N cycles apart, the counter equals N in the cycle the second rise is detected.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: waits for rise -> HIGH. A fall in IDLE is ignored. No VALID on this first rise (no complete period yet).
  - HIGH: on fall, shadow_high <= counter -> LOW.
  - LOW: on rise, PERIOD <= counter, HIGH_TIME <= shadow_high, VALID=1 in the next cycle (registered, one cycle only), TIMEOUT <= 0, counter <= 1 -> HIGH.
- Output latency: VALID and the updated PERIOD/HIGH_TIME appear 1 cycle after the internal rise detect. PERIOD/HIGH_TIME hold their values between strobes.
- Timeout: if counter reaches TIMEOUT_CYCLES while in HIGH or LOW:
  - TIMEOUT <= 1 and state -> IDLE.
  - PERIOD/HIGH_TIME keep their last valid values; no VALID is issued.
- Timeout in IDLE: if counter reaches TIMEOUT_CYCLES in IDLE after at least one prior edge has been seen since reset, TIMEOUT also sets. The flag stays set until the next VALID or reset.
- Simultaneous events: rise and timeout in the same cycle -> the rise takes priority (period measured, no TIMEOUT). Rise and fall cannot coincide by construction.
- Guaranteed resolution: high and low phases each of at least SYNC_STAGES cycles. Shorter glitches may be missed; the FSM must never hang because of them.
- Reset mid-measurement: all state clears immediately (async). The first rise after release restarts from IDLE with no VALID.

Decomposition:
- pulse_meter_pkg: state enum {IDLE, HIGH, LOW} and default width constants (CNT_WIDTH_DEF=24, TIMEOUT_DEF=10_000_000).
- Sub-module sync_edge_detect: SYNC_STAGES-deep synchroniser, history flop, rise/fall outputs; reset to 0 on RESET_N. The top level instantiates it once and contains the FSM, counter and output registers.

Test Plan:
- 1 MHz, 50% duty input (25 cycles high, 25 low), 5 periods -> first rise gives no VALID; then 4 VALID strobes 50 cycles apart, each PERIOD=50, HIGH_TIME=25, TIMEOUT=0.
- 500 Hz square wave -> PERIOD=100000, HIGH_TIME=50000 on each VALID.
- Minimum pulse: 2 cycles high, 3 low, repeated -> PERIOD=5, HIGH_TIME=2; no strobes missing.
- TIMEOUT_CYCLES=1000, 3 periods of 50 cycles, then input held low -> TIMEOUT=1 when counter hits 1000 after the last rise, with PERIOD still 50. Resume toggling -> TIMEOUT clears on the first subsequent VALID.
- Input stuck high after one rise (TIMEOUT_CYCLES=1000) -> TIMEOUT=1 after 1000 cycles, state IDLE, no VALID.
- Assert RESET_N=0 mid-period after some VALIDs -> all outputs are 0 the same cycle. After release, a 50-cycle input gives its first VALID only on the second detected rise.
